// File: rtl/sonic_eth_rx_frame_drop_fifo_pkg.sv
// Shared widths and write-FSM states for the SONIC 10G RX frame-drop FIFO.
package sonic_eth_rx_pkg;

  localparam int unsigned DATA_W_DEF  = 64;
  localparam int unsigned EMPTY_W_DEF = 3;
  localparam int unsigned ENTRY_W_DEF = DATA_W_DEF + EMPTY_W_DEF + 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DISCARD
  } wr_state_e;

  // Stored entry is {data, sop, eop, empty}.
  function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned empty_w);
    return data_w + empty_w + 2;
  endfunction

endpackage

// File: rtl/sonic_eth_rx_frame_drop_fifo_if.sv
// Avalon-ST beat bundle used on both sides of the RX frame-drop FIFO.
interface sonic_eth_rx_frame_drop_fifo_if
  import sonic_eth_rx_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned EMPTY_W = EMPTY_W_DEF
);
  logic               valid;
  logic               ready;
  logic [DATA_W-1:0]  data;
  logic               error;
  logic               startofpacket;
  logic               endofpacket;
  logic [EMPTY_W-1:0] empty;

  modport master (
    output valid, data, error, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  valid, data, error, startofpacket, endofpacket, empty,
    output ready
  );
endinterface

// File: rtl/sonic_eth_rx_frame_drop_fifo_sdp_ram.sv
// Simple dual-port RAM with registered, enable-gated read port.
module sonic_eth_rx_sdp_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WIDTH  = 69
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);
  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register doubles as the show-ahead output stage; it holds while re_i is low.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sonic_eth_rx_frame_drop_fifo.sv
// Store-and-forward RX buffer: drops errored, truncated or overflowing frames whole.
module sonic_eth_rx_frame_drop_fifo
  import sonic_eth_rx_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned EMPTY_W    = EMPTY_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  sonic_eth_rx_frame_drop_fifo_if.slave  in_if,
  sonic_eth_rx_frame_drop_fifo_if.master out_if,
  output logic [31:0] stat_frames_ok,
  output logic [31:0] stat_frames_err,
  output logic [31:0] stat_frames_ovf
);
  localparam int unsigned ENTRY_W = entry_w(DATA_W, EMPTY_W);
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  wr_state_e    state_q, state_d;
  ptr_t         wr_ptr_q, wr_ptr_d;
  ptr_t         commit_ptr_q, commit_ptr_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  ptr_t         base_ptr;
  logic         err_q, err_d;
  logic         out_valid_q, out_valid_d;
  logic         do_write, ram_we, rd_en;
  logic         ok_inc, ovf_inc;
  logic [1:0]   err_inc;
  logic [31:0]  ok_q, err_cnt_q, ovf_q;
  logic [ENTRY_W-1:0] ram_wdata, ram_rdata;

  assign in_if.ready = 1'b1;
  assign ram_wdata   = {in_if.data, in_if.startofpacket, in_if.endofpacket, in_if.empty};

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    err_d        = err_q;
    base_ptr     = wr_ptr_q;
    do_write     = 1'b0;
    ram_we       = 1'b0;
    ok_inc       = 1'b0;
    err_inc      = '0;
    ovf_inc      = 1'b0;
    if (in_if.valid) begin
      if (in_if.startofpacket) begin
        // SOP restarts from any state; a frame still open in WRITE is abandoned first.
        do_write = 1'b1;
        if (state_q == WRITE) begin
          base_ptr = commit_ptr_q;
          err_inc  = 2'd1;
        end
      end else if (state_q == WRITE) begin
        do_write = 1'b1;
      end else if (state_q == DISCARD && in_if.endofpacket) begin
        state_d = IDLE;
      end

      if (do_write) begin
        if (base_ptr + PTR_ONE == rd_ptr_q) begin
          wr_ptr_d = commit_ptr_q;
          ovf_inc  = 1'b1;
          state_d  = in_if.endofpacket ? IDLE : DISCARD;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_d = base_ptr + PTR_ONE;
          err_d    = in_if.startofpacket ? in_if.error : (err_q | in_if.error);
          if (in_if.endofpacket) begin
            state_d = IDLE;
            if (!err_d) begin
              commit_ptr_d = base_ptr + PTR_ONE;
              ok_inc       = 1'b1;
            end else begin
              wr_ptr_d = commit_ptr_q;
              err_inc  = err_inc + 2'd1;
            end
          end else begin
            state_d = WRITE;
          end
        end
      end
    end
  end

  assign rd_en = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || out_if.ready);

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    if (rd_en) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      out_valid_d = 1'b1;
    end else if (out_if.ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      ok_q         <= '0;
      err_cnt_q    <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      ok_q         <= ok_q + 32'(ok_inc);
      err_cnt_q    <= err_cnt_q + 32'(err_inc);
      ovf_q        <= ovf_q + 32'(ovf_inc);
    end
  end

  sonic_eth_rx_sdp_ram #(
    .ADDR_W (DEPTH_LOG2),
    .WIDTH  (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ram_we),
    .waddr_i (base_ptr),
    .wdata_i (ram_wdata),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign out_if.valid = out_valid_q;
  assign out_if.error = 1'b0;
  assign {out_if.data, out_if.startofpacket, out_if.endofpacket, out_if.empty} = ram_rdata;

  assign stat_frames_ok  = ok_q;
  assign stat_frames_err = err_cnt_q;
  assign stat_frames_ovf = ovf_q;
endmodule

// File: tb/tb_sonic_eth_rx_frame_drop_fifo.sv
// Randomized bench for the RX frame-drop FIFO against a frame-level scoreboard.
module tb_sonic_eth_rx_frame_drop_fifo;
  localparam int unsigned DW = 64;
  localparam int unsigned EW = 3;
  localparam int unsigned ENTRY_W = DW + EW + 2;
  typedef logic [ENTRY_W-1:0] entry_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sonic_eth_rx_frame_drop_fifo_if #(.DATA_W(DW), .EMPTY_W(EW)) in_b(), out_b(), in_s(), out_s();
  logic [31:0] ok_b, err_b, ovf_b, ok_s, err_s, ovf_s;

  sonic_eth_rx_frame_drop_fifo #(.DEPTH_LOG2(9), .DATA_W(DW), .EMPTY_W(EW)) u_dut_big (
    .clk (clk), .reset (rst), .in_if (in_b), .out_if (out_b),
    .stat_frames_ok (ok_b), .stat_frames_err (err_b), .stat_frames_ovf (ovf_b)
  );

  sonic_eth_rx_frame_drop_fifo #(.DEPTH_LOG2(3), .DATA_W(DW), .EMPTY_W(EW)) u_dut_small (
    .clk (clk), .reset (rst), .in_if (in_s), .out_if (out_s),
    .stat_frames_ok (ok_s), .stat_frames_err (err_s), .stat_frames_ovf (ovf_s)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned sel = 0;
  int unsigned ready_pct = 100;
  int unsigned exp_ok  [2] = '{0, 0};
  int unsigned exp_err [2] = '{0, 0};
  int unsigned exp_ovf [2] = '{0, 0};
  logic        open_frame [2] = '{1'b0, 1'b0};
  entry_t      exp_b[$];
  entry_t      exp_s[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_ok"},  (sel == 0) ? ok_b  : ok_s,  exp_ok[sel]);
    check_eq({tag, "_err"}, (sel == 0) ? err_b : err_s, exp_err[sel]);
    check_eq({tag, "_ovf"}, (sel == 0) ? ovf_b : ovf_s, exp_ovf[sel]);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic sop, input logic eop, input logic err,
                      input logic [DW-1:0] d, input logic [EW-1:0] emp);
    if (sel == 0) begin
      in_b.valid = 1'b1; in_b.startofpacket = sop; in_b.endofpacket = eop;
      in_b.error = err;  in_b.data = d;            in_b.empty = emp;
    end else begin
      in_s.valid = 1'b1; in_s.startofpacket = sop; in_s.endofpacket = eop;
      in_s.error = err;  in_s.data = d;            in_s.empty = emp;
    end
    @(posedge clk); #1;
    in_b.valid = 1'b0;
    in_s.valid = 1'b0;
  endtask

  // Reference: a frame reaches the output iff it opens with SOP, closes with EOP,
  // carries no error and (as decided by the caller) did not overflow.
  task automatic send_frame(input int unsigned len, input int err_at, input logic with_eop,
                            input logic patterned, input logic ovf_drop);
    entry_t fr[$];
    logic [DW-1:0] d;
    logic [EW-1:0] emp;
    logic eop;
    if (open_frame[sel]) exp_err[sel]++;
    for (int unsigned i = 0; i < len; i++) begin
      eop = with_eop && (i == len - 1);
      d   = patterned ? {8{8'((i + 1) * 17)}} : {$urandom, $urandom};
      emp = eop ? EW'($urandom_range(0, 7)) : '0;
      fr.push_back({d, (i == 0), eop, emp});
      if (eop && err_at < 0 && !ovf_drop) begin
        foreach (fr[k]) begin
          if (sel == 0) exp_b.push_back(fr[k]);
          else exp_s.push_back(fr[k]);
        end
      end
      beat((i == 0), eop, (int'(i) == err_at), d, emp);
    end
    if (with_eop) begin
      if (ovf_drop) exp_ovf[sel]++;
      else if (err_at >= 0) exp_err[sel]++;
      else exp_ok[sel]++;
    end
    open_frame[sel] = !with_eop;
  endtask

  task automatic wait_drain;
    int unsigned n = 0;
    while ((exp_b.size() != 0 || exp_s.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain", 128'(exp_b.size() + exp_s.size()), 128'd0);
    idle(4);
  endtask

  initial begin
    out_b.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_b.ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  entry_t cur_b, held_b, cur_s, held_s;
  logic   stall_b = 1'b0, stall_s = 1'b0;

  always @(negedge clk) begin
    cur_b = {out_b.data, out_b.startofpacket, out_b.endofpacket, out_b.empty};
    if (rst) stall_b = 1'b0;
    else begin
      if (stall_b) check_eq("hold_b", {out_b.valid, cur_b}, {1'b1, held_b});
      stall_b = 1'b0;
      if (out_b.valid && out_b.ready) begin
        if (exp_b.size() == 0) check_eq("extra_b", 128'(exp_b.size()), 128'd1);
        else check_eq("beat_b", cur_b, exp_b.pop_front());
      end else if (out_b.valid) begin
        stall_b = 1'b1;
        held_b  = cur_b;
      end
    end
  end

  always @(negedge clk) begin
    cur_s = {out_s.data, out_s.startofpacket, out_s.endofpacket, out_s.empty};
    if (rst) stall_s = 1'b0;
    else begin
      if (stall_s) check_eq("hold_s", {out_s.valid, cur_s}, {1'b1, held_s});
      stall_s = 1'b0;
      if (out_s.valid && out_s.ready) begin
        if (exp_s.size() == 0) check_eq("extra_s", 128'(exp_s.size()), 128'd1);
        else check_eq("beat_s", cur_s, exp_s.pop_front());
      end else if (out_s.valid) begin
        stall_s = 1'b1;
        held_s  = cur_s;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned kind, len;
    rst = 1'b1;
    in_b.valid = 1'b0; in_b.startofpacket = 1'b0; in_b.endofpacket = 1'b0;
    in_b.error = 1'b0; in_b.data = '0; in_b.empty = '0;
    in_s.valid = 1'b0; in_s.startofpacket = 1'b0; in_s.endofpacket = 1'b0;
    in_s.error = 1'b0; in_s.data = '0; in_s.empty = '0;
    out_s.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", out_b.valid, 1'b0);
    check_eq("rst_out", {out_b.data, out_b.startofpacket, out_b.endofpacket, out_b.empty}, '0);
    check_stats("rst");
    @(posedge clk); #1;

    // 1: patterned 3-beat frame, show-ahead latency of two cycles after the EOP beat
    send_frame(3, -1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("lat_t1", out_b.valid, 1'b0);
    @(negedge clk);
    check_eq("lat_t2", out_b.valid, 1'b1);
    wait_drain;
    check_stats("t1");

    // 2: errored frame then good frame
    send_frame(4, 1, 1'b1, 1'b0, 1'b0);
    send_frame(2, -1, 1'b1, 1'b0, 1'b0);
    wait_drain;
    check_stats("t2");

    // 4: truncated by SOP on beat 3
    send_frame(2, -1, 1'b0, 1'b0, 1'b0);
    send_frame(3, -1, 1'b1, 1'b0, 1'b0);
    wait_drain;
    check_stats("t4");

    // 5: 20 single-beat frames with 50% backpressure
    ready_pct = 50;
    repeat (20) send_frame(1, -1, 1'b1, 1'b0, 1'b0);
    wait_drain;
    check_stats("t5");

    // random mix of good, errored, truncated frames and stray beats
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 12);
      if (kind <= 5) send_frame(len, -1, 1'b1, 1'b0, 1'b0);
      else if (kind <= 7) send_frame(len, int'($urandom_range(0, len - 1)), 1'b1, 1'b0, 1'b0);
      else if (kind == 8) send_frame(len, -1, 1'b0, 1'b0, 1'b0);
      else begin
        if (!open_frame[0]) begin
          repeat ($urandom_range(1, 3))
            beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, '0);
        end
        send_frame(len, -1, 1'b1, 1'b0, 1'b0);
      end
      idle($urandom_range(0, 2));
    end
    wait_drain;
    check_stats("rnd");

    // 3: small buffer overflow, then exact-capacity frame
    sel = 1;
    out_s.ready = 1'b0;
    send_frame(9, -1, 1'b1, 1'b0, 1'b1);
    send_frame(2, -1, 1'b1, 1'b0, 1'b0);
    idle(3);
    check_stats("t3");
    check_eq("t3_showahead", {out_s.valid, out_s.startofpacket}, 2'b11);
    out_s.ready = 1'b1;
    wait_drain;
    out_s.ready = 1'b0;
    send_frame(7, -1, 1'b1, 1'b0, 1'b0);
    idle(3);
    check_stats("t3cap");
    out_s.ready = 1'b1;
    wait_drain;
    check_stats("t3end");
    sel = 0;

    // 6: reset with a stalled committed frame and an open frame in flight
    ready_pct = 0;
    idle(2);
    send_frame(2, -1, 1'b1, 1'b0, 1'b0);
    idle(3);
    send_frame(3, -1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_b.delete();
    for (int unsigned k = 0; k < 2; k++) begin
      exp_ok[k] = 0; exp_err[k] = 0; exp_ovf[k] = 0; open_frame[k] = 1'b0;
    end
    ready_pct = 100;
    @(negedge clk);
    check_eq("t6_valid", out_b.valid, 1'b0);
    check_stats("t6_rst");
    sel = 1;
    check_stats("t6_rst_s");
    sel = 0;
    @(posedge clk); #1;
    send_frame(4, -1, 1'b1, 1'b0, 1'b0);
    wait_drain;
    check_stats("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
